// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: helpers shared by the arbiter mux blocks.
package arb_mux_pkg;
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/common_defs.vh
// common_defs: shared include guard and project-wide macros for datapath blocks.
`ifndef COMMON_DEFS_VH
`define COMMON_DEFS_VH
`define ONEHOT_BIT(k) (1 << (k))
`endif

// File: rtl/onehot_mux.sv
// onehot_mux: AND-OR data select under a one-hot (or zero) select vector.
module onehot_mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]        i_sel,
    input  logic [N-1:0][W-1:0] i_d,
    output logic [W-1:0]        o_d
);
    always_comb begin
        o_d = '0;
        for (int i = 0; i < N; i++) o_d = o_d | (i_d[i] & {W{i_sel[i]}});
    end
endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin one-hot grant, searching upward from ptr then wrapping.
module rr_arb #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt
);
    logic [N-1:0] w_hi;
    logic [N-1:0] w_pool;
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) w_hi[i] = i_req[i] && (i >= int'(i_ptr));
    end
    // lowest set bit of the masked pool, falling back to the full request set
    assign w_pool = (|w_hi) ? w_hi : i_req;
    assign o_gnt  = i_en ? (w_pool & (~w_pool + N'(1))) : '0;
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin arbiter feeding a one-entry output register.
`include "common_defs.vh"
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        i_x_vld,
    input  logic [N-1:0][W-1:0] i_x,
    output logic [N-1:0]        o_x_rdy,
    output logic                o_y_vld,
    output logic [W-1:0]        o_y,
    output logic [N-1:0]        o_y_sel,
    input  logic                i_y_rdy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic          r_y_vld;
    logic [W-1:0]  r_y;
    logic [N-1:0]  r_y_sel;
    logic [PW-1:0] r_ptr;
    logic          w_load;
    logic          w_en;
    logic [N-1:0]  w_gnt;
    logic [W-1:0]  w_d;
    logic [PW-1:0] w_nptr;
    assign w_load = !r_y_vld || i_y_rdy;
    assign w_en   = w_load && !rst;
    rr_arb #(.N(N)) u_arb (.i_req(i_x_vld), .i_ptr(r_ptr), .i_en(w_en), .o_gnt(w_gnt));
    onehot_mux #(.N(N), .W(W)) u_mux (.i_sel(w_gnt), .i_d(i_x), .o_d(w_d));
    always_comb begin
        w_nptr = r_ptr;
        for (int i = 0; i < N; i++) if (w_gnt[i]) w_nptr = PW'(wrap_inc(i, N));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_vld <= 1'b0;
            r_y     <= '0;
            r_y_sel <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_y_vld <= |w_gnt;
            if (|w_gnt) begin
                r_y     <= w_d;
                r_y_sel <= w_gnt;
                r_ptr   <= w_nptr;
            end
        end
    end
    assign o_x_rdy = w_gnt;
    assign o_y_vld = r_y_vld;
    assign o_y     = r_y;
    assign o_y_sel = r_y_sel;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed and soak checks of arb_mux at N=4 and N=3, W=8.
module tb_arb_mux;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      x_vld = '0;
    logic [3:0][7:0] x = '0;
    logic [3:0]      x_rdy;
    logic            y_vld;
    logic [7:0]      y;
    logic [3:0]      y_sel;
    logic            y_rdy = 1'b0;
    logic            rst3 = 1'b1;
    logic [2:0]      v3 = '0;
    logic [2:0][7:0] x3 = '0;
    logic [2:0]      rdy3;
    logic            yv3;
    logic [7:0]      y3;
    logic [2:0]      sel3;
    logic            yr3 = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .i_x_vld(x_vld), .i_x(x), .o_x_rdy(x_rdy),
        .o_y_vld(y_vld), .o_y(y), .o_y_sel(y_sel), .i_y_rdy(y_rdy)
    );
    arb_mux #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst3), .i_x_vld(v3), .i_x(x3), .o_x_rdy(rdy3),
        .o_y_vld(yv3), .o_y(y3), .o_y_sel(sel3), .i_y_rdy(yr3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        x_vld = 4'hF;
        y_rdy = 1'b1;
        x = {8'h44, 8'h33, 8'h22, 8'h11};
        tick;
        tick;
        checks++; if (x_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", x_rdy); end
        checks++; if (y_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", y_vld); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", y); end
        checks++; if (y_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got %b exp 0000", y_sel); end
        checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dut.r_ptr); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [7:0] ed [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [3:0] es [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        x_vld = 4'hF;
        y_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (x_rdy !== es[i]) begin errors++; $display("FAIL rr_rdy[%0d] got %b exp %b", i, x_rdy, es[i]); end
            tick;
            checks++; if (y !== ed[i] || y_vld !== 1'b1) begin errors++; $display("FAIL rr_y[%0d] got %h/%b exp %h/1", i, y, y_vld, ed[i]); end
            checks++; if (y_sel !== es[i]) begin errors++; $display("FAIL rr_sel[%0d] got %b exp %b", i, y_sel, es[i]); end
        end
        checks++; if (dut.r_ptr !== 2'd1) begin errors++; $display("FAIL rr_ptr got %0d exp 1", dut.r_ptr); end
        x_vld = 4'h0;
        #1;
        checks++; if (x_rdy !== 4'b0000) begin errors++; $display("FAIL idle_rdy got %b exp 0000", x_rdy); end
        tick;
        checks++; if (y_vld !== 1'b0 || y !== 8'h11 || y_sel !== 4'b0001) begin errors++; $display("FAIL idle_hold got %b/%h/%b exp 0/11/0001", y_vld, y, y_sel); end
        checks++; if (dut.r_ptr !== 2'd1) begin errors++; $display("FAIL idle_ptr got %0d exp 1", dut.r_ptr); end
    endtask

    task automatic test_stall;
        x[1] = 8'hA5;
        x_vld = 4'b0010;
        y_rdy = 1'b1;
        tick;
        checks++; if (y !== 8'hA5 || y_vld !== 1'b1) begin errors++; $display("FAIL stall_load got %h/%b exp a5/1", y, y_vld); end
        y_rdy = 1'b0;
        x_vld = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (x_rdy !== 4'b0000) begin errors++; $display("FAIL stall_rdy[%0d] got %b exp 0000", i, x_rdy); end
            tick;
            checks++; if (y !== 8'hA5 || y_vld !== 1'b1 || y_sel !== 4'b0010) begin errors++; $display("FAIL stall_hold[%0d] got %h/%b/%b exp a5/1/0010", i, y, y_vld, y_sel); end
            checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL stall_ptr[%0d] got %0d exp 2", i, dut.r_ptr); end
        end
        y_rdy = 1'b1;
        #1;
        checks++; if (x_rdy !== 4'b0100) begin errors++; $display("FAIL resume_rdy got %b exp 0100", x_rdy); end
        tick;
        checks++; if (y !== 8'h33 || y_sel !== 4'b0100) begin errors++; $display("FAIL resume_y got %h/%b exp 33/0100", y, y_sel); end
        checks++; if (dut.r_ptr !== 2'd3) begin errors++; $display("FAIL resume_ptr got %0d exp 3", dut.r_ptr); end
    endtask

    task automatic test_wrap;
        x_vld = 4'b0010;
        #1;
        checks++; if (x_rdy !== 4'b0010) begin errors++; $display("FAIL wrap_rdy got %b exp 0010", x_rdy); end
        tick;
        checks++; if (y !== 8'hA5 || y_sel !== 4'b0010) begin errors++; $display("FAIL wrap_y got %h/%b exp a5/0010", y, y_sel); end
        checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL wrap_ptr got %0d exp 2", dut.r_ptr); end
        y_rdy = 1'b0;
        x_vld = 4'b1000;
        tick;
        x_vld = 4'b0000;
        y_rdy = 1'b1;
        tick;
        checks++; if (y_vld !== 1'b0 || dut.r_ptr !== 2'd2) begin errors++; $display("FAIL withdraw got %b/%0d exp 0/2", y_vld, dut.r_ptr); end
    endtask

    task automatic test_reset_mid;
        x_vld = 4'b0001;
        tick;
        checks++; if (y_vld !== 1'b1 || y !== 8'h11 || dut.r_ptr !== 2'd1) begin errors++; $display("FAIL mid_load got %b/%h/%0d exp 1/11/1", y_vld, y, dut.r_ptr); end
        y_rdy = 1'b0;
        rst = 1'b1;
        x_vld = 4'hF;
        #1;
        checks++; if (x_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_rdy got %b exp 0000", x_rdy); end
        tick;
        checks++; if (y_vld !== 1'b0 || y !== 8'h00 || y_sel !== 4'b0000 || dut.r_ptr !== 2'd0) begin errors++; $display("FAIL mid_rst got %b/%h/%b/%0d exp 0/00/0000/0", y_vld, y, y_sel, dut.r_ptr); end
        rst = 1'b0;
        y_rdy = 1'b1;
        #1;
        checks++; if (x_rdy !== 4'b0001) begin errors++; $display("FAIL post_rst_rdy got %b exp 0001", x_rdy); end
        tick;
        checks++; if (y !== 8'h11 || y_sel !== 4'b0001) begin errors++; $display("FAIL post_rst_y got %h/%b exp 11/0001", y, y_sel); end
    endtask

    task automatic test_n3;
        logic [7:0] ed [3] = '{8'hA1, 8'hB2, 8'hC3};
        logic [2:0] es;
        rst3 = 1'b1;
        tick;
        rst3 = 1'b0;
        v3 = 3'b111;
        yr3 = 1'b1;
        x3 = {8'hC3, 8'hB2, 8'hA1};
        for (int i = 0; i < 6; i++) begin
            es = 3'b001 << (i % 3);
            #1;
            checks++; if (rdy3 !== es) begin errors++; $display("FAIL n3_rdy[%0d] got %b exp %b", i, rdy3, es); end
            tick;
            checks++; if (sel3 !== es || y3 !== ed[i % 3]) begin errors++; $display("FAIL n3_y[%0d] got %b/%h exp %b/%h", i, sel3, y3, es, ed[i % 3]); end
            checks++; if (dut3.r_ptr !== 2'((i + 1) % 3)) begin errors++; $display("FAIL n3_ptr[%0d] got %0d exp %0d", i, dut3.r_ptr, (i + 1) % 3); end
        end
        v3 = 3'b000;
    endtask

    task automatic test_soak;
        int sent [4] = '{0, 0, 0, 0};
        int recv [4] = '{0, 0, 0, 0};
        int waits [4] = '{0, 0, 0, 0};
        logic [3:0] pend = '0;
        int ch;
        rst = 1'b1;
        x_vld = '0;
        tick;
        rst = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                x_vld[c] = pend[c] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
                x[c] = {2'(c), 6'(sent[c])};
            end
            y_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (y_vld && y_rdy) begin
                ch = 0;
                for (int c = 0; c < 4; c++) if (y_sel[c]) ch = c;
                checks++; if ($countones(y_sel) != 1 || y !== {2'(ch), 6'(recv[ch])}) begin errors++; $display("FAIL soak_word[%0d] got %h sel %b exp %h", cyc, y, y_sel, {2'(ch), 6'(recv[ch])}); end
                recv[ch]++;
            end
            for (int c = 0; c < 4; c++) begin
                if (x_vld[c] && x_rdy[c]) begin
                    sent[c]++;
                    waits[c] = 0;
                end else if (x_vld[c]) begin
                    if (|x_rdy) waits[c]++;
                    checks++; if (waits[c] >= 4) begin errors++; $display("FAIL soak_fair[%0d] ch %0d waited %0d exp <4", cyc, c, waits[c]); end
                end else waits[c] = 0;
                pend[c] = x_vld[c] && !x_rdy[c];
            end
            tick;
        end
        x_vld = '0;
        y_rdy = 1'b1;
        #1;
        if (y_vld) begin
            ch = 0;
            for (int c = 0; c < 4; c++) if (y_sel[c]) ch = c;
            checks++; if (y !== {2'(ch), 6'(recv[ch])}) begin errors++; $display("FAIL soak_drain got %h exp %h", y, {2'(ch), 6'(recv[ch])}); end
            recv[ch]++;
        end
        tick;
        for (int c = 0; c < 4; c++) begin
            checks++; if (recv[c] != sent[c]) begin errors++; $display("FAIL soak_count ch %0d got %0d exp %0d", c, recv[c], sent[c]); end
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_stall;
        test_wrap;
        test_reset_mid;
        test_n3;
        test_soak;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter N, default 4: number of input channels, N >= 1.
REQ-002 The block SHALL have parameter W, default 32: data width per channel, W >= 1.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_x_vld, input, N: per-channel request valid.
REQ-006 The block SHALL have port i_x, input, N x W (packed [N-1:0][W-1:0]): per-channel data.
REQ-007 The block SHALL have port o_x_rdy, output, N: per-channel accept; one-hot or zero.
REQ-008 The block SHALL have port o_y_vld, output, 1: output data valid.
REQ-009 The block SHALL have port o_y, output, W: selected data.
REQ-010 The block SHALL have port o_y_sel, output, N: one-hot index of the channel that sourced o_y.
REQ-011 The block SHALL have port i_y_rdy, input, 1: downstream accept.

Function
REQ-012 A transfer on channel j SHALL occur in a cycle when i_x_vld[j] and o_x_rdy[j] are both 1; an output transfer SHALL occur when o_y_vld and i_y_rdy are both 1.
REQ-013 The block SHALL define load = (!o_y_vld | i_y_rdy); no channel SHALL be granted when load is 0, so o_x_rdy = 0.
REQ-014 When load is 1, the block SHALL grant at most one requesting channel by round-robin: the lowest index k >= ptr with i_x_vld[k]=1, else the lowest index k < ptr with i_x_vld[k]=1.
REQ-015 o_x_rdy SHALL equal the grant vector, combinationally from i_x_vld, ptr and i_y_rdy; no path SHALL exist from o_x_rdy back to i_x_vld.
REQ-016 On a grant of k, the block SHALL register o_y <= i_x[k], o_y_sel <= one-hot(k), o_y_vld <= 1, and ptr <= (k+1) mod N; latency from input transfer to o_y_vld SHALL be exactly 1 cycle.
REQ-017 When load is 1 and no channel requests, the block SHALL set o_y_vld <= 0; o_y and o_y_sel SHALL hold their values and ptr SHALL be unchanged.
REQ-018 While o_y_vld=1 and i_y_rdy=0, o_y, o_y_sel and o_y_vld SHALL hold stable and ptr SHALL not change.
REQ-019 Sustained throughput SHALL be one transfer per cycle when i_y_rdy=1 (output drains and reloads in the same cycle).
REQ-020 When N=1, the block SHALL reduce to a single-entry pipeline register with ptr fixed at 0 and o_y_sel=1 whenever o_y_vld=1.
REQ-021 ptr SHALL be ceil(log2(N)) bits, minimum 1, and SHALL only take values 0..N-1; wrap from N-1 to 0 SHALL be explicit for non-power-of-2 N.
REQ-022 An input deasserting i_x_vld without having been granted SHALL be permitted and SHALL not affect ptr.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL force o_y_vld=0, o_y='0, o_y_sel='0 and ptr=0.
REQ-024 o_x_rdy SHALL be 0 in any cycle where rst=1; reset asserted mid-transfer SHALL discard the held output word without handshake.
REQ-025 In the first cycle after reset deassertion, channel 0 SHALL have highest priority.

Structure
REQ-026 The round-robin selection SHALL be a separate sub-module rr_arb (parameter N; inputs request vector, ptr, enable; output one-hot grant), reusable elsewhere.
REQ-027 The data selection SHALL be a one-hot AND-OR of i_x under the grant vector, using the existing common mux block; no priority-encoded data path.
REQ-028 No new package typedefs SHALL be required; the ptr width localparam SHALL be computed in-module, and the block SHALL include common_defs.vh.

Verification (N=4, W=8 unless noted)
REQ-029 The bench SHALL cover: reset, then i_x_vld=4'b1111 with i_x={8'h44,8'h33,8'h22,8'h11} held and i_y_rdy=1 -> o_y sequence 11,22,33,44,11 on consecutive cycles, with o_y_sel 0001,0010,0100,1000,0001.
REQ-030 The bench SHALL cover: o_y_vld=1, o_y=8'hA5 held, then i_y_rdy=0 for 3 cycles with all channels requesting -> o_y stays A5, o_x_rdy=0 throughout, ptr unchanged.
REQ-031 The bench SHALL cover: ptr=3 and only i_x_vld[1]=1 -> grant 0010, next ptr=2 (wrap search).
REQ-032 The bench SHALL cover: rst=1 asserted while o_y_vld=1 -> next cycle o_y_vld=0, o_y=0, then first grant with 4'b1111 requesting goes to channel 0.
REQ-033 The bench SHALL cover: N=3, all requesting for 6 grants -> grant order 0,1,2,0,1,2 and ptr never equals 3.
REQ-034 The bench SHALL cover: a random-valid/random-ready soak with a scoreboard -> no word lost or duplicated, and every persistently requesting channel granted within N output transfers.
